// File: rtl/sdram_burst_reader_if.sv
// Bus bundle for sdram_burst_reader: command channel, output beat stream and
// the Avalon-MM burst read master signals. The reader connects through the
// master modport; the load engine / SDRAM slave side uses the slave modport.
interface sdram_burst_reader_if #(
  parameter int SDRAM_W = 128,
  parameter int ADDR_W  = 32,
  parameter int BURST_W = 11,
  parameter int LEN_W   = 24
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [LEN_W-1:0]   cmd_len;

  logic               out_valid;
  logic               out_ready;
  logic [SDRAM_W-1:0] out_data;
  logic               out_last;

  logic [ADDR_W-1:0]  avm_address;
  logic [BURST_W-1:0] avm_burstcount;
  logic               avm_read;
  logic               avm_waitrequest;
  logic [SDRAM_W-1:0] avm_readdata;
  logic               avm_readdatavalid;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    output cmd_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output avm_address, avm_burstcount, avm_read,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    input  cmd_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  avm_address, avm_burstcount, avm_read,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read initiator for the NPU SDRAM port. Splits a command
// (word address, beat count) into bursts of at most MAX_BURST, issues them
// only when the beat FIFO has room for every outstanding beat, and streams
// returned beats out on a valid/ready interface with a last marker.
// Optional: define SDRAM_RD_PERF_EN to add saturating busy/stall/backpressure
// cycle counters (cleared by each accepted non-empty command).
module sdram_burst_reader #(
  parameter int SDRAM_W    = 128,
  parameter int ADDR_W     = 32,
  parameter int BURST_W    = 11,
  parameter int MAX_BURST  = 64,
  parameter int FIFO_DEPTH = 128,
  parameter int LEN_W      = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_burst_reader_if.master bus,
  output logic                 busy,
  output logic                 protocol_err
`ifdef SDRAM_RD_PERF_EN
  ,
  output logic [31:0]          perf_busy_cycles,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_bp_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   out_cnt_q;
  logic [CNT_W-1:0]   outst_q, outst_d;
  logic [CNT_W-1:0]   fcnt_q, fcnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic               rd_q, rd_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [BURST_W-1:0] rcnt_q, rcnt_d;
  logic               perr_q;
  logic [SDRAM_W-1:0] mem [FIFO_DEPTH];

  logic               accept, push, pop, cmd_fire, out_valid;
  logic [ADDR_W-1:0]  addr_nx;
  logic [LEN_W-1:0]   rem_nx;
  logic [CNT_W-1:0]   blen_nx, free_nx;

  assign out_valid = (fcnt_q != '0);
  assign accept    = rd_q && !bus.avm_waitrequest;
  assign push      = bus.avm_readdatavalid && (outst_q != '0);
  assign pop       = out_valid && bus.out_ready;
  assign cmd_fire  = bus.cmd_valid && (state_q == IDLE);

  assign bus.cmd_ready      = (state_q == IDLE);
  assign bus.out_valid      = out_valid;
  assign bus.out_data       = mem[rd_ptr_q];
  assign bus.out_last       = out_valid && (out_cnt_q == LEN_W'(1));
  assign bus.avm_address    = raddr_q;
  assign bus.avm_burstcount = rcnt_q;
  assign bus.avm_read       = rd_q;
  assign busy               = (state_q != IDLE);
  assign protocol_err       = perr_q;

  // Post-edge counts and next burst; the credit check uses them so a new
  // burst can be presented straight after the previous one is accepted.
  always_comb begin
    outst_d = outst_q + (accept ? CNT_W'(rcnt_q) : '0) - (push ? CNT_W'(1) : '0);
    fcnt_d  = fcnt_q + CNT_W'(push) - CNT_W'(pop);
    addr_nx = accept ? addr_q + ADDR_W'(rcnt_q) : addr_q;
    rem_nx  = accept ? rem_q - LEN_W'(rcnt_q) : rem_q;
    blen_nx = (rem_nx < LEN_W'(MAX_BURST)) ? CNT_W'(rem_nx) : CNT_W'(MAX_BURST);
    free_nx = CNT_W'(FIFO_DEPTH) - fcnt_d - outst_d;
  end

  // Next state and registered Avalon request (held while waitrequest stalls).
  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    raddr_d = raddr_q;
    rcnt_d  = rcnt_q;
    if (rd_q && bus.avm_waitrequest) begin
      rd_d = 1'b1;
    end else if (state_q == ISSUE && rem_nx != '0 && free_nx >= blen_nx) begin
      rd_d    = 1'b1;
      raddr_d = addr_nx;
      rcnt_d  = BURST_W'(blen_nx);
    end
    case (state_q)
      IDLE:    if (cmd_fire && bus.cmd_len != '0) state_d = ISSUE;
      ISSUE:   if (rem_nx == '0) state_d = DRAIN;
      DRAIN:   if (pop && bus.out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, counters and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      out_cnt_q <= '0;
      outst_q   <= '0;
      fcnt_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_q      <= 1'b0;
      raddr_q   <= '0;
      rcnt_q    <= '0;
      perr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      raddr_q <= raddr_d;
      rcnt_q  <= rcnt_d;
      outst_q <= outst_d;
      fcnt_q  <= fcnt_d;
      if (cmd_fire && bus.cmd_len != '0) begin
        addr_q    <= bus.cmd_addr;
        rem_q     <= bus.cmd_len;
        out_cnt_q <= bus.cmd_len;
      end else begin
        addr_q <= addr_nx;
        rem_q  <= rem_nx;
        if (pop) out_cnt_q <= out_cnt_q - LEN_W'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (bus.avm_readdatavalid && outst_q == '0) perr_q <= 1'b1;
    end
  end

  // Beat storage; no reset needed, occupancy is tracked by fcnt_q.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.avm_readdata;
  end

`ifdef SDRAM_RD_PERF_EN
  // Saturating performance counters, cleared per non-empty command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
      perf_bp_cycles    <= '0;
    end else if (cmd_fire && bus.cmd_len != '0) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
      perf_bp_cycles    <= '0;
    end else begin
      if (busy && perf_busy_cycles != '1)
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (rd_q && bus.avm_waitrequest && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (out_valid && !bus.out_ready && perf_bp_cycles != '1)
        perf_bp_cycles <= perf_bp_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_burst_reader.sv
// Testbench for sdram_burst_reader: directed commands against a simple
// Avalon slave model; a transfer-level model checks bursts, beats and flags.
module tb_sdram_burst_reader;
  localparam int SDRAM_W    = 128;
  localparam int ADDR_W     = 32;
  localparam int BURST_W    = 11;
  localparam int MAX_BURST  = 64;
  localparam int FIFO_DEPTH = 128;
  localparam int LEN_W      = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, perr;
  always #5 clk = ~clk;

  sdram_burst_reader_if #(.SDRAM_W(SDRAM_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
                          .LEN_W(LEN_W)) bus ();

`ifdef SDRAM_RD_PERF_EN
  logic [31:0] perf_busy, perf_stall, perf_bp;
`endif

  sdram_burst_reader #(.SDRAM_W(SDRAM_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W),
                       .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH),
                       .LEN_W(LEN_W)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .busy(busy),
    .protocol_err(perr)
`ifdef SDRAM_RD_PERF_EN
    ,
    .perf_busy_cycles(perf_busy),
    .perf_stall_cycles(perf_stall),
    .perf_bp_cycles(perf_bp)
`endif
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name, int act, int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic logic [127:0] pat(logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'd7};
  endfunction

  // Transfer-level model
  typedef struct packed {logic [127:0] data; logic last;} beat_t;
  typedef struct packed {logic [31:0] addr; logic [10:0] cnt;} burst_t;
  beat_t  exp_q[$];
  burst_t exp_b[$];
  int     mdl_out = 0, mdl_fifo = 0;
  logic   exp_perr = 1'b0;
  int     n_acc = 0, n_pop = 0, beat_idx = 0, last_at = 0, stall_seen = 0;
  logic [31:0]  last_acc_addr = '0;
  logic [10:0]  last_acc_cnt = '0;
  logic [127:0] last_pop_data = '0;

  // Slave model state
  typedef struct {logic [31:0] addr; int due;} sbeat_t;
  sbeat_t sq[$];
  int cyc = 0;
  int stall_budget = 0;

  // Avalon slave: accepts bursts, returns one beat per cycle from 3 cycles on.
  initial begin
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b0;
    bus.avm_readdata      = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.avm_read && !bus.avm_waitrequest)
        for (int i = 0; i < int'(bus.avm_burstcount); i++)
          sq.push_back('{bus.avm_address + 32'(i), cyc + 3});
      if (bus.avm_read && bus.avm_waitrequest && stall_budget > 0) stall_budget--;
      @(posedge clk);
      cyc++;
      #1;
      bus.avm_waitrequest = (stall_budget > 0);
      if (sq.size() > 0 && sq[0].due <= cyc) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = pat(sq[0].addr);
        void'(sq.pop_front());
      end else begin
        bus.avm_readdatavalid = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    logic         prev_stall, prev_bp, prev_last, acc, mpop;
    logic [31:0]  prev_addr;
    logic [10:0]  prev_cnt;
    logic [127:0] prev_data;
    prev_stall = 1'b0; prev_bp = 1'b0; prev_last = 1'b0;
    prev_addr = '0; prev_cnt = '0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); exp_b.delete();
        mdl_out = 0; mdl_fifo = 0; exp_perr = 1'b0;
        prev_stall = 1'b0; prev_bp = 1'b0; beat_idx = 0;
        continue;
      end
      if (prev_stall) begin
        chk("hold_read", bus.avm_read, 1);
        chk("hold_address", bus.avm_address, prev_addr);
        chk("hold_burstcount", bus.avm_burstcount, prev_cnt);
      end
      acc = bus.avm_read && !bus.avm_waitrequest;
      if (acc) begin
        n_acc++;
        last_acc_addr = bus.avm_address;
        last_acc_cnt  = bus.avm_burstcount;
        if (exp_b.size() == 0) fail("unexpected_burst", n_acc, 0);
        else begin
          chk("burst_address", bus.avm_address, exp_b[0].addr);
          chk("burst_count", bus.avm_burstcount, exp_b[0].cnt);
          void'(exp_b.pop_front());
        end
        chk("credit", (mdl_out + mdl_fifo + int'(bus.avm_burstcount)) <= FIFO_DEPTH, 1);
      end
      if (bus.avm_read && bus.avm_waitrequest) stall_seen++;
      prev_stall = bus.avm_read && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      prev_cnt   = bus.avm_burstcount;

      chk("out_valid", bus.out_valid, mdl_fifo != 0);
      chk("cmd_ready_vs_busy", bus.cmd_ready, !busy);
      chk("protocol_err", perr, exp_perr);
      if (prev_bp) begin
        chk("hold_out_data", bus.out_data, prev_data);
        chk("hold_out_last", bus.out_last, prev_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_beat", n_pop, 0);
        else begin
          chk("out_data", bus.out_data, exp_q[0].data);
          chk("out_last", bus.out_last, exp_q[0].last);
          void'(exp_q.pop_front());
        end
        n_pop++;
        beat_idx++;
        last_pop_data = bus.out_data;
        if (bus.out_last) begin
          last_at  = beat_idx;
          beat_idx = 0;
        end
      end
      prev_bp   = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;

      mpop = (mdl_fifo != 0) && bus.out_ready;
      if (bus.avm_readdatavalid) begin
        if (mdl_out == 0) exp_perr = 1'b1;
        else begin
          mdl_out--;
          mdl_fifo++;
        end
      end
      if (acc) mdl_out += int'(bus.avm_burstcount);
      if (mpop) mdl_fifo--;
    end
  end

  task automatic do_cmd(input logic [31:0] a, input int len);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = LEN_W'(len);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      if (ok) break;
    end
    #1;
    bus.cmd_valid = 1'b0;
    if (!ok) fail("cmd_handshake_timeout", 0, 1);
    else if (len > 0) begin
      for (int i = 0; i < len; i++) exp_q.push_back('{pat(a + 32'(i)), i == len - 1});
      for (int r = len, o = 0; r > 0; ) begin
        int b;
        b = (r < MAX_BURST) ? r : MAX_BURST;
        exp_b.push_back('{a + 32'(o), 11'(b)});
        o += b;
        r -= b;
      end
    end
  endtask

  task automatic wait_done(input int max_cycles);
    logic done;
    done = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && sq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("transfer_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, p0, s0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_avm_read", bus.avm_read, 0);
    chk("rst_avm_address", bus.avm_address, 0);
    chk("rst_avm_burstcount", bus.avm_burstcount, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_protocol_err", perr, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single short burst
    a0 = n_acc; p0 = n_pop;
    do_cmd(32'h100, 4);
    wait_done(100);
    chk("t1_bursts", n_acc - a0, 1);
    chk("t1_addr", last_acc_addr, 32'h100);
    chk("t1_cnt", last_acc_cnt, 4);
    chk("t1_beats", n_pop - p0, 4);
    chk("t1_last_at", last_at, 4);
    chk("t1_last_data", last_pop_data, 128'h00000103_FFFFFEFC_A5A55B59_0000010A);
    chk("t1_busy", busy, 0);
    chk("t1_cmd_ready", bus.cmd_ready, 1);

    // Split into 64/64/22
    a0 = n_acc; p0 = n_pop;
    do_cmd(32'h1000, 150);
    wait_done(400);
    chk("t2_bursts", n_acc - a0, 3);
    chk("t2_last_addr", last_acc_addr, 32'h1080);
    chk("t2_last_cnt", last_acc_cnt, 22);
    chk("t2_beats", n_pop - p0, 150);
    chk("t2_last_at", last_at, 150);

    // Waitrequest stall on the first burst
    a0 = n_acc; s0 = stall_seen;
    stall_budget = 5;
    do_cmd(32'h2000, 4);
    wait_done(100);
    chk("t3_stall_cycles", stall_seen - s0, 5);
    chk("t3_bursts", n_acc - a0, 1);

    // Back-pressure limits issue to the FIFO credit
    a0 = n_acc; p0 = n_pop;
    bus.out_ready = 1'b0;
    do_cmd(32'h3000, 200);
    repeat (250) @(negedge clk);
    chk("t4_bursts_blocked", n_acc - a0, 2);
    chk("t4_read_low", bus.avm_read, 0);
    chk("t4_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done(600);
    chk("t4_bursts", n_acc - a0, 4);
    chk("t4_last_cnt", last_acc_cnt, 8);
    chk("t4_beats", n_pop - p0, 200);
    chk("t4_last_at", last_at, 200);

    // Zero-length command
    a0 = n_acc;
    do_cmd(32'h5000, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t5_busy", busy, 0);
      chk("t5_read", bus.avm_read, 0);
      chk("t5_cmd_ready", bus.cmd_ready, 1);
    end
    chk("t5_bursts", n_acc - a0, 0);

    // Reset mid-burst, then late beats
    a0 = n_acc;
    do_cmd(32'h4000, 64);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (n_acc > a0) break;
    end
    chk("t6_accepted", n_acc - a0, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_read", bus.avm_read, 0);
    chk("t6_rst_address", bus.avm_address, 0);
    chk("t6_rst_burstcount", bus.avm_burstcount, 0);
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cmd_ready", bus.cmd_ready, 1);
    chk("t6_rst_perr", perr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("t6_perr_sticky", perr, 1);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
